// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-lite controller and the datapath muxes it drives.
// Contents: state codes, opcode/func constants, mux select encodings, instruction-class struct.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned ALU_OP_W = 3;

  // Sequencer states; codes are visible on the debug state port.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_WB_LUI   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_JR       = 4'd12,
    S_ADV      = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

  localparam logic [FUNC_W-1:0] FUNC_ADDU = 6'h21;
  localparam logic [FUNC_W-1:0] FUNC_SUBU = 6'h23;
  localparam logic [FUNC_W-1:0] FUNC_JR   = 6'h08;

  // pc_src: next-PC mux
  localparam logic [SEL_W-1:0] PC_SRC_SEQ = 2'd0;  // pc+4
  localparam logic [SEL_W-1:0] PC_SRC_BR  = 2'd1;  // pc+4+(ext<<2)
  localparam logic [SEL_W-1:0] PC_SRC_J   = 2'd2;  // {pc[31:28],addr26,00}
  localparam logic [SEL_W-1:0] PC_SRC_RS  = 2'd3;  // rs

  // reg_dst: GRF write-address mux
  localparam logic [SEL_W-1:0] REG_DST_RT = 2'd0;
  localparam logic [SEL_W-1:0] REG_DST_RD = 2'd1;
  localparam logic [SEL_W-1:0] REG_DST_RA = 2'd2;

  // wd_sel: GRF write-data mux
  localparam logic [SEL_W-1:0] WD_ALU  = 2'd0;
  localparam logic [SEL_W-1:0] WD_DM   = 2'd1;
  localparam logic [SEL_W-1:0] WD_LUI  = 2'd2;
  localparam logic [SEL_W-1:0] WD_LINK = 2'd3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd2;

  // One-hot instruction class; exactly one field is set for any op/func.
  typedef struct packed {
    logic r_alu;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic jal;
    logic jr;
    logic bad;
  } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
// Ports: op, func (from IR) -> cls (one-hot instruction class, bad when unsupported).
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output instr_class_t      cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FUNC_ADDU, FUNC_SUBU: cls.r_alu = 1'b1;
          FUNC_JR:              cls.jr    = 1'b1;
          default:              cls.bad   = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the MIPS-lite datapath.
// Ports: clk, reset (async active-low); op/func from IR, zero (ALU), mem_ready (DM handshake);
//        datapath controls ir_write, pc_write, pc_src, reg_write, reg_dst, wd_sel, alu_src,
//        alu_op, ext_sign, mem_read, mem_write; illegal pulse; debug state; retired counter.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNC_W-1:0]   func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                pc_write,
  output logic [SEL_W-1:0]    pc_src,
  output logic                reg_write,
  output logic [SEL_W-1:0]    reg_dst,
  output logic [SEL_W-1:0]    wd_sel,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                ext_sign,
  output logic                mem_read,
  output logic                mem_write,
  output logic                illegal,
  output logic [STATE_W-1:0]  state,
  output logic [CNT_W-1:0]    retired
);

  state_t       state_q;
  state_t       state_d;
  instr_class_t cls;
  logic         is_sub;

  // IR is stable from DECODE until the next FETCH, so the class stays valid for EXEC/WB selects.
  mc_decode u_decode (
    .op   (op),
    .func (func),
    .cls  (cls)
  );

  assign is_sub = (func == FUNC_SUBU);
  assign state  = state_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d   = state_q;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_SRC_SEQ;
    reg_write = 1'b0;
    reg_dst   = REG_DST_RT;
    wd_sel    = WD_ALU;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    ext_sign  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        illegal = cls.bad;
        state_d = S_ADV;
        if (cls.r_alu)           state_d = S_EXEC_R;
        else if (cls.ori)        state_d = S_EXEC_I;
        else if (cls.lw | cls.sw) state_d = S_MEM_ADDR;
        else if (cls.beq)        state_d = S_BRANCH;
        else if (cls.lui)        state_d = S_WB_LUI;
        else if (cls.jal)        state_d = S_JAL;
        else if (cls.jr)         state_d = S_JR;
      end
      S_EXEC_R: begin
        alu_op  = is_sub ? ALU_SUB : ALU_ADD;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src = 1'b1;
        alu_op  = ALU_OR;
        state_d = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src  = 1'b1;
        ext_sign = 1'b1;
        state_d  = cls.sw ? S_MEM_WR : S_MEM_RD;
      end
      // Address operands held so the DM address stays stable during the access.
      S_MEM_RD: begin
        alu_src  = 1'b1;
        ext_sign = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        alu_src   = 1'b1;
        ext_sign  = 1'b1;
        mem_write = 1'b1;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      // ALU operands held from the preceding EXEC state.
      S_WB_ALU: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (cls.r_alu) begin
          reg_dst = REG_DST_RD;
          alu_op  = is_sub ? ALU_SUB : ALU_ADD;
        end else begin
          alu_src = 1'b1;
          alu_op  = ALU_OR;
        end
        state_d = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wd_sel    = WD_DM;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_LUI: begin
        reg_write = 1'b1;
        wd_sel    = WD_LUI;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op   = ALU_SUB;
        ext_sign = 1'b1;
        pc_write = 1'b1;
        pc_src   = zero ? PC_SRC_BR : PC_SRC_SEQ;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        reg_write = 1'b1;
        reg_dst   = REG_DST_RA;
        wd_sel    = WD_LINK;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_J;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_RS;
        state_d  = S_FETCH;
      end
      S_ADV: begin
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every control at once, abandoning any in-flight DM access.
    if (!reset) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_SRC_SEQ;
      reg_write = 1'b0;
      reg_dst   = REG_DST_RT;
      wd_sel    = WD_ALU;
      alu_src   = 1'b0;
      alu_op    = ALU_ADD;
      ext_sign  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  // Retired-instruction counter: one per PC update, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (pc_write) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected-cycle sequences built
// from the instruction-level behaviour, checked every cycle, plus literal spot checks.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, func;
  logic        zero, mem_ready;
  logic        ir_write, pc_write, reg_write, alu_src, ext_sign;
  logic        mem_read, mem_write, illegal;
  logic [1:0]  pc_src, reg_dst, wd_sel;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .func      (func),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .alu_src   (alu_src),
    .alu_op    (alu_op),
    .ext_sign  (ext_sign),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .illegal   (illegal),
    .state     (state),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       ext_sign;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic       mem_ready;  // stimulus for this cycle
  } exp_t;

  exp_t        seq[$];
  exp_t        cur;
  bit          chk_en = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_ret = '0;
  logic [1:0]  lit_beq = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  function automatic exp_t idle();
    exp_t e;
    e.st = 4'd0; e.ir_write = 0; e.pc_write = 0; e.pc_src = 2'd0; e.reg_write = 0;
    e.reg_dst = 2'd0; e.wd_sel = 2'd0; e.alu_src = 0; e.alu_op = 3'd0; e.ext_sign = 0;
    e.mem_read = 0; e.mem_write = 0; e.illegal = 0; e.mem_ready = 1'b1;
    return e;
  endfunction

  // Expected cycle-by-cycle trace for one instruction.
  function automatic void build(logic [5:0] o, logic [5:0] f, logic z, int stalls);
    exp_t e;
    bit   r_alu, jr, known;
    r_alu = (o == 6'h00) && (f == 6'h21 || f == 6'h23);
    jr    = (o == 6'h00) && (f == 6'h08);
    known = r_alu || jr || o == 6'h0D || o == 6'h23 || o == 6'h2B ||
            o == 6'h04 || o == 6'h0F || o == 6'h03;
    seq.delete();
    e = idle(); e.ir_write = 1; seq.push_back(e);
    e = idle(); e.st = 4'd1; e.illegal = !known; seq.push_back(e);
    if (r_alu) begin
      e = idle(); e.st = 4'd2; e.alu_op = (f == 6'h23) ? 3'd1 : 3'd0; seq.push_back(e);
      e.st = 4'd7; e.reg_write = 1; e.reg_dst = 2'd1; e.pc_write = 1; seq.push_back(e);
    end else if (o == 6'h0D) begin
      e = idle(); e.st = 4'd3; e.alu_src = 1; e.alu_op = 3'd2; seq.push_back(e);
      e.st = 4'd7; e.reg_write = 1; e.pc_write = 1; seq.push_back(e);
    end else if (o == 6'h23 || o == 6'h2B) begin
      e = idle(); e.st = 4'd4; e.alu_src = 1; e.ext_sign = 1; seq.push_back(e);
      if (o == 6'h23) begin
        e.st = 4'd5; e.mem_read = 1;
        e.mem_ready = 0;
        for (int i = 0; i < stalls; i++) seq.push_back(e);
        e.mem_ready = 1; seq.push_back(e);
        e = idle(); e.st = 4'd8; e.reg_write = 1; e.wd_sel = 2'd1; e.pc_write = 1;
        seq.push_back(e);
      end else begin
        e.st = 4'd6; e.mem_write = 1;
        e.mem_ready = 0;
        for (int i = 0; i < stalls; i++) seq.push_back(e);
        e.mem_ready = 1; e.pc_write = 1; seq.push_back(e);
      end
    end else if (o == 6'h04) begin
      e = idle(); e.st = 4'd10; e.alu_op = 3'd1; e.ext_sign = 1; e.pc_write = 1;
      e.pc_src = z ? 2'd1 : 2'd0; seq.push_back(e);
    end else if (o == 6'h0F) begin
      e = idle(); e.st = 4'd9; e.reg_write = 1; e.wd_sel = 2'd2; e.pc_write = 1; seq.push_back(e);
    end else if (o == 6'h03) begin
      e = idle(); e.st = 4'd11; e.reg_write = 1; e.reg_dst = 2'd2; e.wd_sel = 2'd3;
      e.pc_write = 1; e.pc_src = 2'd2; seq.push_back(e);
    end else if (jr) begin
      e = idle(); e.st = 4'd12; e.pc_write = 1; e.pc_src = 2'd3; seq.push_back(e);
    end else begin
      e = idle(); e.st = 4'd13; e.pc_write = 1; seq.push_back(e);
    end
  endfunction

  // Hand-computed spot checks at specific points of specific instructions.
  task automatic lit_hook(input logic [5:0] o, input logic [5:0] f, input logic [3:0] st);
    if (st == 4'd1 && o == 6'h3F) chk("lit_illegal_decode", illegal, 1);
    if (st == 4'd7 && o == 6'h00 && f == 6'h21) begin
      chk("lit_addu_reg_write", reg_write, 1);
      chk("lit_addu_reg_dst", reg_dst, 1);
    end
    if (st == 4'd5) chk("lit_lw_mem_read", mem_read, 1);
    if (st == 4'd8) chk("lit_wb_mem_wd_sel", wd_sel, 1);
    if (st == 4'd10) begin
      chk("lit_beq_pc_src", pc_src, lit_beq);
      chk("lit_beq_pc_write", pc_write, 1);
    end
    if (st == 4'd11) begin
      chk("lit_jal_reg_dst", reg_dst, 2);
      chk("lit_jal_wd_sel", wd_sel, 3);
      chk("lit_jal_pc_src", pc_src, 2);
    end
    if (st == 4'd12) begin
      chk("lit_jr_pc_src", pc_src, 3);
      chk("lit_jr_reg_write", reg_write, 0);
    end
    if (st == 4'd13 && o == 6'h3F) begin
      chk("lit_adv_pc_write", pc_write, 1);
      chk("lit_adv_pc_src", pc_src, 0);
      chk("lit_adv_reg_write", reg_write, 0);
    end
  endtask

  // Drive one instruction; starts and ends just after a rising edge.
  task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input int stalls, input int max_recs);
    build(o, f, z, stalls);
    op = o; func = f;
    for (int i = 0; i < seq.size() && i < max_recs; i++) begin
      cur = seq[i];
      mem_ready = cur.mem_ready;
      zero = z;
      chk_en = 1'b1;
      #2;
      lit_hook(o, f, cur.st);
      @(posedge clk);
      #1;
    end
  endtask

  // Every-cycle comparison against the expected trace.
  always @(negedge clk) begin
    if (!reset) begin
      model_ret = '0;
    end else if (chk_en) begin
      chk("state", 32'(state), 32'(cur.st));
      chk("ir_write", 32'(ir_write), 32'(cur.ir_write));
      chk("pc_write", 32'(pc_write), 32'(cur.pc_write));
      chk("pc_src", 32'(pc_src), 32'(cur.pc_src));
      chk("reg_write", 32'(reg_write), 32'(cur.reg_write));
      chk("reg_dst", 32'(reg_dst), 32'(cur.reg_dst));
      chk("wd_sel", 32'(wd_sel), 32'(cur.wd_sel));
      chk("alu_src", 32'(alu_src), 32'(cur.alu_src));
      chk("alu_op", 32'(alu_op), 32'(cur.alu_op));
      chk("ext_sign", 32'(ext_sign), 32'(cur.ext_sign));
      chk("mem_read", 32'(mem_read), 32'(cur.mem_read));
      chk("mem_write", 32'(mem_write), 32'(cur.mem_write));
      chk("illegal", 32'(illegal), 32'(cur.illegal));
      chk("retired", retired, model_ret);
      chk("rw_mw_exclusive", 32'(reg_write & mem_write), 32'd0);
      if (cur.pc_write) model_ret = model_ret + 32'd1;
    end
  end

  initial begin
    reset = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("rst_state", 32'(state), 0);
    chk("rst_retired", retired, 0);
    chk("rst_ir_write", 32'(ir_write), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    run(6'h00, 6'h21, 1'b1, 0, 99);             // addu
    chk("lit_retired_after_addu", retired, 1);
    run(6'h00, 6'h23, 1'b1, 0, 99);             // subu
    run(6'h0D, 6'h00, 1'b1, 0, 99);             // ori
    run(6'h23, 6'h00, 1'b1, 3, 99);             // lw, 3 stall cycles
    chk("lit_lw_stall_len", 32'(seq.size()), 8);
    run(6'h23, 6'h00, 1'b1, 0, 99);             // lw, no stall
    run(6'h2B, 6'h00, 1'b1, 0, 99);             // sw, no stall
    run(6'h2B, 6'h00, 1'b1, 2, 99);             // sw, 2 stall cycles
    lit_beq = 2'd1;
    run(6'h04, 6'h00, 1'b1, 0, 99);             // beq taken
    lit_beq = 2'd0;
    run(6'h04, 6'h00, 1'b0, 0, 99);             // beq not taken
    run(6'h0F, 6'h00, 1'b1, 0, 99);             // lui
    run(6'h03, 6'h00, 1'b1, 0, 99);             // jal
    run(6'h00, 6'h08, 1'b1, 0, 99);             // jr
    run(6'h3F, 6'h00, 1'b1, 0, 99);             // illegal op
    run(6'h00, 6'h00, 1'b1, 0, 99);             // illegal R func
    chk("lit_retired_before_reset", retired, 14);

    // sw stalled in MEM_WR, then reset mid-access
    run(6'h2B, 6'h00, 1'b1, 5, 5);
    chk_en = 1'b0;
    chk("lit_mem_write_before_reset", 32'(mem_write), 1);
    reset = 1'b0;
    #1;
    chk("lit_reset_mem_write", 32'(mem_write), 0);
    chk("lit_reset_state", 32'(state), 0);
    chk("lit_reset_retired", retired, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    run(6'h00, 6'h21, 1'b1, 0, 99);             // addu after reset
    chk_en = 1'b0;
    chk("lit_retired_after_reset_addu", retired, 1);
    chk("lit_final_state", 32'(state), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
